// File: rtl/cla_mp_seq.sv
// Byte-serial adder/subtractor: one 8-bit carry-lookahead slice is reused once per cycle,
// LSB byte first. Valid/ready on the request side and on the result side.

module cla_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       c_msb
);
  logic [7:0] g, p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate terms gated by the propagate run above them
  always_comb begin : carry_tree
    logic pp;
    logic cn;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      cn = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cn = cn | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cn | (pp & cin);
    end
  end

  assign sum   = p ^ c[7:0];
  assign cout  = c[8];
  assign c_msb = c[7];
endmodule

module cla_mp_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [IW+2:0] base;
  logic [7:0]    add_sum;
  logic          add_cout, add_cmsb;

  assign base = {idx_q, 3'b000};

  cla_adder u_slice (
    .a     (a_q[base +: 8]),
    .b     (b_q[base +: 8]),
    .cin   (carry_q),
    .sum   (add_sum),
    .cout  (add_cout),
    .c_msb (add_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1
          a_d     = op_a;
          b_d     = op_b ^ {W{sub}};
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: 8] = add_sum;
        carry_d          = add_cout;
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
          ovf_d   = add_cmsb ^ add_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule
